// File: rtl/serial_link_bringup_pkg.sv
// Shared types and constants for the serial link bring-up sequencer: FSM states,
// register-bus structs, config register offsets and the per-state write table.
package serial_link_bringup_pkg;

  localparam int AddrWidth = 32;
  localparam int DataWidth = 32;
  localparam int StrbWidth = DataWidth / 8;

  // Register offsets of the link configuration space
  localparam logic [AddrWidth-1:0] SERIAL_LINK_CTRL_OFFSET                 = 32'h00;
  localparam logic [AddrWidth-1:0] SERIAL_LINK_ISOLATED_OFFSET             = 32'h04;
  localparam logic [AddrWidth-1:0] SERIAL_LINK_CHANNEL_ALLOC_TX_CFG_OFFSET = 32'h20;
  localparam logic [AddrWidth-1:0] SERIAL_LINK_CHANNEL_ALLOC_RX_CFG_OFFSET = 32'h24;

  localparam logic [DataWidth-1:0] CTRL_RST_CLKGATE = 32'h300;
  localparam logic [DataWidth-1:0] CTRL_CLK_EN      = 32'h302;
  localparam logic [DataWidth-1:0] CTRL_RST_REL     = 32'h303;
  localparam logic [DataWidth-1:0] CTRL_DEISO       = 32'h03;
  localparam logic [DataWidth-1:0] ALLOC_CFG        = 32'h3;

  typedef struct packed {
    logic [AddrWidth-1:0] addr;
    logic                 write;
    logic [DataWidth-1:0] wdata;
    logic [StrbWidth-1:0] wstrb;
    logic                 valid;
  } bringup_req_t;

  typedef struct packed {
    logic [DataWidth-1:0] rdata;
    logic                 error;
    logic                 ready;
  } bringup_rsp_t;

  typedef enum logic [3:0] {
    IDLE, WR_CTRL0, WR_CTRL1, WR_CTRL2, WR_ALLOC_TX, WR_ALLOC_RX,
    WAIT, WR_DEISO, RD_ISO, DONE, ERR
  } state_e;

  typedef struct packed {
    logic                 en;
    logic [AddrWidth-1:0] offset;
    logic [DataWidth-1:0] wdata;
  } wr_beat_t;

  // en is clear for every state that does not issue a write
  function automatic wr_beat_t write_beat(input state_e state);
    write_beat = '0;
    case (state)
      WR_CTRL0:    write_beat = '{1'b1, SERIAL_LINK_CTRL_OFFSET, CTRL_RST_CLKGATE};
      WR_CTRL1:    write_beat = '{1'b1, SERIAL_LINK_CTRL_OFFSET, CTRL_CLK_EN};
      WR_CTRL2:    write_beat = '{1'b1, SERIAL_LINK_CTRL_OFFSET, CTRL_RST_REL};
      WR_ALLOC_TX: write_beat = '{1'b1, SERIAL_LINK_CHANNEL_ALLOC_TX_CFG_OFFSET, ALLOC_CFG};
      WR_ALLOC_RX: write_beat = '{1'b1, SERIAL_LINK_CHANNEL_ALLOC_RX_CFG_OFFSET, ALLOC_CFG};
      WR_DEISO:    write_beat = '{1'b1, SERIAL_LINK_CTRL_OFFSET, CTRL_DEISO};
      default:     write_beat = '0;
    endcase
  endfunction

endpackage

// File: rtl/serial_link_bringup_seq.sv
// Register-bus master that walks a serial link through its enable sequence and
// polls the isolation status; all outputs come straight from flops.
module serial_link_bringup_seq
  import serial_link_bringup_pkg::*;
#(
  parameter int  NumChannels = 1,
  parameter int  WaitCycles  = 50,
  parameter int  MaxPolls    = 1024,
  parameter type cfg_req_t   = bringup_req_t,
  parameter type cfg_rsp_t   = bringup_rsp_t
) (
  input  logic     clk_1,
  input  logic     rst_1_n,
  input  logic     start_i,
  output cfg_req_t cfg_req_o,
  input  cfg_rsp_t cfg_rsp_i,
  output logic     busy_o,
  output logic     done_o,
  output logic     error_o
);

  localparam int WaitW = $clog2(WaitCycles + 1);
  localparam int PollW = $clog2(MaxPolls + 1);
  localparam logic [WaitW-1:0] WaitLast = WaitW'(WaitCycles - 1);
  localparam logic [PollW-1:0] PollLast = PollW'(MaxPolls - 1);
  localparam logic [PollW-1:0] PollMax  = PollW'(MaxPolls);

  state_e           state_reg, state_next;
  logic [WaitW-1:0] wait_cnt_reg, wait_cnt_next;
  logic [PollW-1:0] poll_cnt_reg, poll_cnt_next;
  cfg_req_t         req_reg, req_next;
  logic             busy_reg, busy_next;
  logic             done_reg, done_next;
  logic             error_reg, error_next;
  logic             handshake;
  wr_beat_t         beat;

  assign handshake = req_reg.valid && cfg_rsp_i.ready;

  always_comb begin
    state_next    = state_reg;
    wait_cnt_next = wait_cnt_reg;
    poll_cnt_next = poll_cnt_reg;
    unique case (state_reg)
      IDLE, DONE, ERR: begin
        if (start_i) begin
          state_next    = WR_CTRL0;
          wait_cnt_next = '0;
          poll_cnt_next = '0;
        end
      end
      WR_CTRL0:    if (handshake) state_next = WR_CTRL1;
      WR_CTRL1:    if (handshake) state_next = WR_CTRL2;
      WR_CTRL2:    if (handshake) state_next = (NumChannels > 1) ? WR_ALLOC_TX : WAIT;
      WR_ALLOC_TX: if (handshake) state_next = WR_ALLOC_RX;
      WR_ALLOC_RX: if (handshake) state_next = WAIT;
      WAIT: begin
        if (wait_cnt_reg == WaitLast) state_next = WR_DEISO;
        else                          wait_cnt_next = wait_cnt_reg + WaitW'(1);
      end
      WR_DEISO:    if (handshake) state_next = RD_ISO;
      RD_ISO: begin
        // Staying in RD_ISO keeps valid high, which reissues the read back-to-back
        if (handshake) begin
          if (cfg_rsp_i.rdata == '0) begin
            state_next = DONE;
          end else begin
            if (poll_cnt_reg != PollMax) poll_cnt_next = poll_cnt_reg + PollW'(1);
            if (poll_cnt_reg >= PollLast) state_next = ERR;
          end
        end
      end
      default: state_next = IDLE;
    endcase
    if (handshake && cfg_rsp_i.error) state_next = ERR;
  end

  // Outputs are decoded from the next state so they line up with it after the flop
  always_comb begin
    req_next   = '0;
    beat       = write_beat(state_next);
    busy_next  = !(state_next inside {IDLE, DONE, ERR});
    done_next  = (state_next == DONE);
    error_next = (state_next == ERR);
    if (state_next == RD_ISO) begin
      req_next.valid = 1'b1;
      req_next.addr  = SERIAL_LINK_ISOLATED_OFFSET;
    end else if (beat.en) begin
      req_next.valid = 1'b1;
      req_next.write = 1'b1;
      req_next.addr  = beat.offset;
      req_next.wdata = beat.wdata;
      req_next.wstrb = '1;
    end
  end

  always_ff @(posedge clk_1 or posedge rst_1_n) begin
    if (rst_1_n) begin
      state_reg    <= IDLE;
      wait_cnt_reg <= '0;
      poll_cnt_reg <= '0;
      req_reg      <= '0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      error_reg    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      poll_cnt_reg <= poll_cnt_next;
      req_reg      <= req_next;
      busy_reg     <= busy_next;
      done_reg     <= done_next;
      error_reg    <= error_next;
    end
  end

  assign cfg_req_o = req_reg;
  assign busy_o    = busy_reg;
  assign done_o    = done_reg;
  assign error_o   = error_reg;

endmodule

// File: tb/tb_serial_link_bringup_seq.sv
// Bench for serial_link_bringup_seq: two configurations driven by a randomized
// responder, checked every cycle against an access-list model of the sequence.
module tb_serial_link_bringup_seq;
  import serial_link_bringup_pkg::*;

  localparam int NI = 2;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    bit          wait_after;
  } acc_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_s [NI];
  int   iso_n [NI];
  int   err_at [NI];
  int   max_stall [NI];

  wire        busy_w [NI];
  wire        done_w [NI];
  wire        err_w [NI];
  wire        req_nz_w [NI];
  wire [31:0] hs_n_w [NI];
  wire [31:0] wr_n_w [NI];
  wire [31:0] rd_n_w [NI];
  wire [31:0] done_cyc_w [NI];
  wire [31:0] err_cyc_w [NI];
  wire [31:0] hs_cyc_w [NI][8];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  for (genvar gi = 0; gi < NI; gi++) begin : g_inst
    localparam int NCH = (gi == 0) ? 1 : 2;
    localparam int WC  = (gi == 0) ? 50 : 5;
    localparam int MP  = (gi == 0) ? 1024 : 4;

    bringup_req_t req;
    bringup_rsp_t rsp;
    logic busy, done, error;

    serial_link_bringup_seq #(
      .NumChannels(NCH), .WaitCycles(WC), .MaxPolls(MP),
      .cfg_req_t(bringup_req_t), .cfg_rsp_t(bringup_rsp_t)
    ) u_dut (
      .clk_1(clk), .rst_1_n(rst), .start_i(start_s[gi]),
      .cfg_req_o(req), .cfg_rsp_i(rsp),
      .busy_o(busy), .done_o(done), .error_o(error)
    );

    acc_t q[$];
    acc_t head;
    bit   m_busy, m_done, m_err, m_valid, accept, rdy, e;
    int   gap, polls, idx, stall_left, cyc;
    logic [31:0] rd;
    int   hs_n, wr_n, rd_n, done_cyc, err_cyc;
    int   hs_cyc [8];

    assign busy_w[gi]     = busy;
    assign done_w[gi]     = done;
    assign err_w[gi]      = error;
    assign req_nz_w[gi]   = |req;
    assign hs_n_w[gi]     = hs_n;
    assign wr_n_w[gi]     = wr_n;
    assign rd_n_w[gi]     = rd_n;
    assign done_cyc_w[gi] = done_cyc;
    assign err_cyc_w[gi]  = err_cyc;
    for (genvar gk = 0; gk < 8; gk++) begin : g_log
      assign hs_cyc_w[gi][gk] = hs_cyc[gk];
    end

    always @(negedge clk) begin
      if (rst) begin
        chk($sformatf("i%0d rst req", gi), req, 0);
        chk($sformatf("i%0d rst busy", gi), busy, 0);
        chk($sformatf("i%0d rst done", gi), done, 0);
        chk($sformatf("i%0d rst error", gi), error, 0);
        q.delete();
        m_busy = 0; m_done = 0; m_err = 0; gap = 0; polls = 0; idx = 0;
        stall_left = 0;
        rsp = '0;
      end else begin
        accept = start_s[gi] && !m_busy;
        if (accept) begin
          cyc = 0; hs_n = 0; wr_n = 0; rd_n = 0; done_cyc = -1; err_cyc = -1;
          foreach (hs_cyc[k]) hs_cyc[k] = -1;
        end else begin
          cyc++;
        end

        // Outputs of this cycle versus what the access list says
        m_valid = m_busy && (gap == 0);
        if (q.size() > 0) head = q[0];
        else head = '{wr: 1'b0, addr: SERIAL_LINK_ISOLATED_OFFSET, data: 32'h0, wait_after: 1'b0};
        chk($sformatf("i%0d busy c%0d", gi, cyc), busy, m_busy);
        chk($sformatf("i%0d done c%0d", gi, cyc), done, m_done);
        chk($sformatf("i%0d error c%0d", gi, cyc), error, m_err);
        chk($sformatf("i%0d valid c%0d", gi, cyc), req.valid, m_valid);
        if (m_valid) begin
          chk($sformatf("i%0d addr c%0d", gi, cyc), req.addr, head.addr);
          chk($sformatf("i%0d write c%0d", gi, cyc), req.write, head.wr);
          if (head.wr) begin
            chk($sformatf("i%0d wdata c%0d", gi, cyc), req.wdata, head.data);
            chk($sformatf("i%0d wstrb c%0d", gi, cyc), req.wstrb, 4'hF);
          end
        end

        // Responder for this cycle
        if (m_valid) begin
          rdy = (stall_left == 0);
          if (!rdy) stall_left--;
        end else begin
          rdy = 1'($urandom_range(0, 1));
        end
        e  = m_valid && rdy && (idx == err_at[gi]);
        rd = (m_valid && !head.wr) ? ((polls < iso_n[gi]) ? 32'h3 : 32'h0) : $urandom;
        rsp = '{rdata: rd, error: e, ready: rdy};

        if (req.valid && rdy) begin
          if (hs_n < 8) hs_cyc[hs_n] = cyc;
          hs_n++;
          if (req.write) wr_n++;
          else rd_n++;
        end
        if (!accept && done && done_cyc < 0) done_cyc = cyc;
        if (!accept && error && err_cyc < 0) err_cyc = cyc;

        // Advance the model
        if (m_busy && gap > 0) begin
          gap--;
        end else if (m_valid && rdy) begin
          idx++;
          stall_left = $urandom_range(0, max_stall[gi]);
          if (e) begin
            m_busy = 0; m_err = 1;
          end else if (head.wr) begin
            void'(q.pop_front());
            if (head.wait_after) gap = WC;
          end else if (rd == 0) begin
            m_busy = 0; m_done = 1;
          end else begin
            polls++;
            if (polls == MP) begin
              m_busy = 0; m_err = 1;
            end
          end
        end
        if (accept) begin
          q.delete();
          q.push_back('{1'b1, SERIAL_LINK_CTRL_OFFSET, 32'h300, 1'b0});
          q.push_back('{1'b1, SERIAL_LINK_CTRL_OFFSET, 32'h302, 1'b0});
          q.push_back('{1'b1, SERIAL_LINK_CTRL_OFFSET, 32'h303, NCH == 1});
          if (NCH > 1) begin
            q.push_back('{1'b1, SERIAL_LINK_CHANNEL_ALLOC_TX_CFG_OFFSET, 32'h3, 1'b0});
            q.push_back('{1'b1, SERIAL_LINK_CHANNEL_ALLOC_RX_CFG_OFFSET, 32'h3, 1'b1});
          end
          q.push_back('{1'b1, SERIAL_LINK_CTRL_OFFSET, 32'h03, 1'b0});
          m_busy = 1; m_done = 0; m_err = 0; gap = 0; polls = 0; idx = 0;
          stall_left = $urandom_range(0, max_stall[gi]);
        end
      end
    end
  end

  // One start pulse, then wait (bounded) for the sequence to end; poke adds a busy-time start
  task automatic run(input int i, input int isn, input int ea, input int ms, input bit poke);
    iso_n[i] = isn; err_at[i] = ea; max_stall[i] = ms;
    @(posedge clk); #1 start_s[i] = 1'b1;
    @(posedge clk); #1 start_s[i] = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      if (poke && c == 5) start_s[i] = 1'b1;
      if (c == 6) start_s[i] = 1'b0;
      if (!busy_w[i]) break;
    end
    start_s[i] = 1'b0;
    chk($sformatf("i%0d run ends", i), busy_w[i], 0);
    repeat (2) @(posedge clk);
    #1;
    $display("[TB] inst%0d iso_n=%0d err_at=%0d stall=%0d: hs=%0d wr=%0d rd=%0d done=%0b error=%0b",
             i, isn, ea, ms, hs_n_w[i], wr_n_w[i], rd_n_w[i], done_w[i], err_w[i]);
  endtask

  initial begin
    for (int i = 0; i < NI; i++) begin
      start_s[i] = 1'b0; iso_n[i] = 0; err_at[i] = -1; max_stall[i] = 0;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Single channel, no stalls: exact cycle positions
    run(0, 0, -1, 0, 0);
    chk("i0 hs count", hs_n_w[0], 5);
    chk("i0 ctrl0 cycle", hs_cyc_w[0][0], 1);
    chk("i0 ctrl1 cycle", hs_cyc_w[0][1], 2);
    chk("i0 ctrl2 cycle", hs_cyc_w[0][2], 3);
    chk("i0 deiso cycle", hs_cyc_w[0][3], 54);
    chk("i0 read cycle", hs_cyc_w[0][4], 55);
    chk("i0 done cycle", done_cyc_w[0], 56);
    chk("i0 done", done_w[0], 1);

    // Stalls and three nonzero polls
    run(0, 3, -1, 5, 0);
    chk("i0 poll reads", rd_n_w[0], 4);
    chk("i0 poll writes", wr_n_w[0], 4);
    chk("i0 poll done", done_w[0], 1);

    // Bus error on the 0x302 write, then a clean restart
    run(0, 0, 1, 0, 0);
    chk("i0 err hs", hs_n_w[0], 2);
    chk("i0 err cycle", err_cyc_w[0], 3);
    chk("i0 err flag", err_w[0], 1);
    chk("i0 err no done", done_w[0], 0);
    run(0, 0, -1, 2, 0);
    chk("i0 restart done", done_w[0], 1);
    chk("i0 restart err clear", err_w[0], 0);
    chk("i0 restart writes", wr_n_w[0], 4);

    // Reset pulse in the middle of WAIT
    @(posedge clk); #1 start_s[0] = 1'b1;
    @(posedge clk); #1 start_s[0] = 1'b0;
    repeat (18) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("i0 async rst req", req_nz_w[0], 0);
    chk("i0 async rst busy", busy_w[0], 0);
    chk("i0 async rst done", done_w[0], 0);
    chk("i0 async rst error", err_w[0], 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    run(0, 0, -1, 0, 1);
    chk("i0 replay hs", hs_n_w[0], 5);
    chk("i0 replay done cycle", done_cyc_w[0], 56);

    // Two channels: allocator writes, poll limit and error boundaries
    run(1, 0, -1, 0, 0);
    chk("i1 hs count", hs_n_w[1], 7);
    chk("i1 alloc tx cycle", hs_cyc_w[1][3], 4);
    chk("i1 alloc rx cycle", hs_cyc_w[1][4], 5);
    chk("i1 deiso cycle", hs_cyc_w[1][5], 11);
    chk("i1 done cycle", done_cyc_w[1], 13);
    run(1, 0, -1, 5, 1);
    chk("i1 stall writes", wr_n_w[1], 6);
    chk("i1 stall done", done_w[1], 1);
    run(1, 99, -1, 3, 0);
    chk("i1 timeout reads", rd_n_w[1], 4);
    chk("i1 timeout error", err_w[1], 1);
    chk("i1 timeout no done", done_w[1], 0);
    run(1, 3, -1, 2, 0);
    chk("i1 last poll reads", rd_n_w[1], 4);
    chk("i1 last poll done", done_w[1], 1);
    chk("i1 last poll no error", err_w[1], 0);
    run(1, 0, 6, 1, 0);
    chk("i1 read err reads", rd_n_w[1], 1);
    chk("i1 read err flag", err_w[1], 1);
    chk("i1 read err no done", done_w[1], 0);
    run(1, 0, 4, 0, 0);
    chk("i1 alloc err hs", hs_n_w[1], 5);
    chk("i1 alloc err flag", err_w[1], 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
